// File: rtl/fm_spy_pkg.sv
// fm_spy_pkg: shared types and defaults for the fast-monitoring spy capture.
//   fm_spy_state_t : per-channel capture state (IDLE/ARMED/POST/FROZEN)
//   FM_*           : default parameter values of fm_spy_capture
//   clog2()        : ceiling log2, used to size the readback slice index
package fm_spy_pkg;

    typedef enum logic [1:0] {
        FM_IDLE   = 2'd0,
        FM_ARMED  = 2'd1,
        FM_POST   = 2'd2,
        FM_FROZEN = 2'd3
    } fm_spy_state_t;

    localparam int FM_N_CH   = 4;
    localparam int FM_DATA_W = 256;
    localparam int FM_ADDR_W = 10;
    localparam int FM_RD_W   = 32;
    localparam int FM_RD_LAT = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fm_spy_ram.sv
// fm_spy_ram: simple dual-port capture buffer, one per channel.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is registered and updates only when re
//   rdata        : read data, one cycle after re (old data on same-address write)
// Storage and read register carry no reset so the array maps onto block RAM.
module fm_spy_ram #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Capture write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; holds its value between requests.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/fm_spy_capture.sv
// fm_spy_capture: N_CH circular spy buffers with arm/trigger/post/freeze control
// and a shared, pipelined, sliced readback port.
//   clk_hs, rst_hs           : clock, asynchronous active-high reset
//   ch_data, ch_vld          : monitored streams
//   arm, trig                : per-channel single-cycle pulses
//   freeze                   : per-channel level, forces FROZEN from ARMED/POST
//   post_cnt                 : words captured after the trigger word
//   ch_state, trig_addr, wrapped : registered per-channel status
//   rd_en, rd_ch, rd_addr    : read request {word, slice}
//   rd_data, rd_valid, rd_err: read response, RD_LAT cycles after rd_en
module fm_spy_capture
    import fm_spy_pkg::*;
#(
    parameter int N_CH   = FM_N_CH,
    parameter int DATA_W = FM_DATA_W,
    parameter int ADDR_W = FM_ADDR_W,
    parameter int RD_W   = FM_RD_W,
    parameter int RD_LAT = FM_RD_LAT
) (
    input  logic                                       clk_hs,
    input  logic                                       rst_hs,
    input  logic [N_CH-1:0][DATA_W-1:0]                ch_data,
    input  logic [N_CH-1:0]                            ch_vld,
    input  logic [N_CH-1:0]                            arm,
    input  logic [N_CH-1:0]                            trig,
    input  logic [N_CH-1:0]                            freeze,
    input  logic [ADDR_W-1:0]                          post_cnt,
    output logic [N_CH-1:0][1:0]                       ch_state,
    output logic [N_CH-1:0][ADDR_W-1:0]                trig_addr,
    output logic [N_CH-1:0]                            wrapped,
    input  logic                                       rd_en,
    input  logic [3:0]                                 rd_ch,
    input  logic [ADDR_W+clog2(DATA_W/RD_W)-1:0]       rd_addr,
    output logic [RD_W-1:0]                            rd_data,
    output logic                                       rd_valid,
    output logic                                       rd_err
);

    localparam int SLICES = DATA_W / RD_W;
    localparam int SL_W   = clog2(SLICES);

    logic [ADDR_W-1:0] rd_word_s;
    logic [SL_W-1:0]   rd_slice_s;
    logic [N_CH-1:0]   frozen_s;
    logic [DATA_W-1:0] ram_q_s [N_CH];

    assign rd_word_s  = rd_addr[ADDR_W+SL_W-1:SL_W];
    assign rd_slice_s = rd_addr[SL_W-1:0];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        fm_spy_state_t     state_r;
        fm_spy_state_t     nxt_state_s;
        logic [ADDR_W-1:0] wr_ptr_r;
        logic [ADDR_W-1:0] post_rem_r;
        logic [ADDR_W-1:0] trig_addr_r;
        logic              wrapped_r;
        logic              we_s;
        logic              trig_take_s;

        // Next state and write enable; arm beats freeze beats trig.
        always_comb begin
            nxt_state_s = state_r;
            we_s        = 1'b0;
            trig_take_s = 1'b0;
            if (arm[c]) begin
                nxt_state_s = FM_ARMED;
            end else if (freeze[c] && (state_r == FM_ARMED || state_r == FM_POST)) begin
                nxt_state_s = FM_FROZEN;
            end else begin
                case (state_r)
                    FM_ARMED: begin
                        // The trigger word itself is written at trig_addr.
                        we_s = ch_vld[c];
                        if (trig[c]) begin
                            nxt_state_s = FM_POST;
                            trig_take_s = 1'b1;
                        end else begin
                            nxt_state_s = FM_ARMED;
                        end
                    end
                    FM_POST: begin
                        // Exhausted post count freezes without writing.
                        if (post_rem_r == {ADDR_W{1'b0}}) begin
                            nxt_state_s = FM_FROZEN;
                        end else begin
                            we_s        = ch_vld[c];
                            nxt_state_s = FM_POST;
                        end
                    end
                    FM_IDLE:   nxt_state_s = FM_IDLE;
                    FM_FROZEN: nxt_state_s = FM_FROZEN;
                    default:   nxt_state_s = FM_IDLE;
                endcase
            end
        end

        // Channel state, write pointer, wrap flag and trigger bookkeeping.
        always_ff @(posedge clk_hs or posedge rst_hs) begin
            if (rst_hs) begin
                state_r     <= FM_IDLE;
                wr_ptr_r    <= {ADDR_W{1'b0}};
                post_rem_r  <= {ADDR_W{1'b0}};
                trig_addr_r <= {ADDR_W{1'b0}};
                wrapped_r   <= 1'b0;
            end else begin
                state_r <= nxt_state_s;
                if (arm[c]) begin
                    wr_ptr_r  <= {ADDR_W{1'b0}};
                    wrapped_r <= 1'b0;
                end else if (we_s) begin
                    wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                    if (&wr_ptr_r) begin
                        wrapped_r <= 1'b1;
                    end
                end
                if (trig_take_s) begin
                    trig_addr_r <= wr_ptr_r;
                    post_rem_r  <= post_cnt;
                end else if (we_s && state_r == FM_POST) begin
                    post_rem_r <= post_rem_r - ADDR_W'(1);
                end
            end
        end

        fm_spy_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk_hs),
            .we    (we_s),
            .waddr (wr_ptr_r),
            .wdata (ch_data[c]),
            .re    (rd_en),
            .raddr (rd_word_s),
            .rdata (ram_q_s[c])
        );

        assign ch_state[c]  = state_r;
        assign trig_addr[c] = trig_addr_r;
        assign wrapped[c]   = wrapped_r;
        assign frozen_s[c]  = (state_r == FM_FROZEN);
    end

    // ---------------- read path ----------------
    logic            bad_ch_s;
    logic            sel_frozen_s;
    logic            m_vld_r;
    logic [3:0]      m_ch_r;
    logic [SL_W-1:0] m_slice_r;
    logic            m_bad_r;
    logic            m_err_r;
    logic [DATA_W-1:0] mux_word_s;
    logic [RD_W-1:0]   mux_data_s;

    assign bad_ch_s = ({1'b0, rd_ch} >= 5'(N_CH));

    // Frozen flag of the requested channel, sampled in the request cycle.
    always_comb begin
        sel_frozen_s = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch == 4'(c)) begin
                sel_frozen_s = frozen_s[c];
            end else begin
                sel_frozen_s = sel_frozen_s;
            end
        end
    end

    // Request metadata aligned with the one-cycle RAM read; held between reads
    // so the RD_LAT=1 output does not change while rd_valid is low.
    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            m_vld_r   <= 1'b0;
            m_ch_r    <= 4'd0;
            m_slice_r <= {SL_W{1'b0}};
            m_bad_r   <= 1'b1;
            m_err_r   <= 1'b0;
        end else begin
            m_vld_r <= rd_en;
            if (rd_en) begin
                m_ch_r    <= rd_ch;
                m_slice_r <= rd_slice_s;
                m_bad_r   <= bad_ch_s;
                m_err_r   <= bad_ch_s | ~sel_frozen_s;
            end
        end
    end

    // Channel and slice mux; out-of-range channels read as zero.
    always_comb begin
        mux_word_s = {DATA_W{1'b0}};
        mux_data_s = {RD_W{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (m_ch_r == 4'(c)) begin
                mux_word_s = ram_q_s[c];
            end else begin
                mux_word_s = mux_word_s;
            end
        end
        if (!m_bad_r) begin
            for (int s = 0; s < SLICES; s++) begin
                if (m_slice_r == SL_W'(s)) begin
                    mux_data_s = mux_word_s[s*RD_W +: RD_W];
                end else begin
                    mux_data_s = mux_data_s;
                end
            end
        end else begin
            mux_data_s = {RD_W{1'b0}};
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_data  = mux_data_s;
        assign rd_valid = m_vld_r;
        assign rd_err   = m_err_r;
    end else begin : g_pipe
        logic [RD_W-1:0]   p_data_r [RD_LAT-1];
        logic [RD_LAT-2:0] p_vld_r;
        logic [RD_LAT-2:0] p_err_r;

        // Remaining latency stages; data only advances with a valid beat.
        always_ff @(posedge clk_hs or posedge rst_hs) begin
            if (rst_hs) begin
                p_vld_r <= {(RD_LAT-1){1'b0}};
                p_err_r <= {(RD_LAT-1){1'b0}};
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    p_data_r[k] <= {RD_W{1'b0}};
                end
            end else begin
                p_vld_r[0] <= m_vld_r;
                p_err_r[0] <= m_vld_r & m_err_r;
                if (m_vld_r) begin
                    p_data_r[0] <= mux_data_s;
                end
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    p_vld_r[k] <= p_vld_r[k-1];
                    p_err_r[k] <= p_err_r[k-1];
                    if (p_vld_r[k-1]) begin
                        p_data_r[k] <= p_data_r[k-1];
                    end
                end
            end
        end

        assign rd_data  = p_data_r[RD_LAT-2];
        assign rd_valid = p_vld_r[RD_LAT-2];
        assign rd_err   = p_err_r[RD_LAT-2];
    end

endmodule
